// File: rtl/sopc_data_bus_pkg.sv
// Shared types for the SOPC data-side bus: state encoding, wait counter and latched request.
package sopc_data_bus_pkg;

  localparam int unsigned RegBusW  = 32;
  localparam int unsigned SelW     = 4;
  localparam int unsigned WaitCntW = 4;

  typedef logic [RegBusW-1:0]  reg_bus_t;
  typedef logic [WaitCntW-1:0] wait_cnt_t;
  typedef logic [SelW-1:0]     byte_sel_t;

  typedef enum logic [1:0] {
    BusIdle   = 2'd0,
    BusAccess = 2'd1,
    BusDone   = 2'd2,
    BusErr    = 2'd3
  } bus_state_e;

  typedef struct packed {
    logic      we;
    reg_bus_t  addr;
    byte_sel_t sel;
    reg_bus_t  wdata;
  } bus_req_t;

  // Wait-state count of slave i from the packed 4-bit-per-slave vector.
  function automatic wait_cnt_t wait_of(input logic [63:0] vec, input int unsigned i);
    return wait_cnt_t'(vec >> (WaitCntW * i));
  endfunction

endpackage

// File: rtl/sopc_data_bus_if.sv
// CPU-side ram_* port plus fan-out to NUM_SLV slaves; port names are as seen by the bus.
interface sopc_data_bus_if #(
  parameter int unsigned NUM_SLV = 4
);
  import sopc_data_bus_pkg::*;

  logic                       cpu_ce_i;
  logic                       cpu_we_i;
  reg_bus_t                   cpu_addr_i;
  byte_sel_t                  cpu_sel_i;
  reg_bus_t                   cpu_data_i;
  reg_bus_t                   cpu_data_o;
  logic                       cpu_stall_o;
  logic                       bus_err_o;
  logic [NUM_SLV-1:0]         slv_ce_o;
  logic                       slv_we_o;
  reg_bus_t                   slv_addr_o;
  byte_sel_t                  slv_sel_o;
  reg_bus_t                   slv_data_o;
  logic [RegBusW*NUM_SLV-1:0] slv_data_i;

  modport slave (
    input  cpu_ce_i, cpu_we_i, cpu_addr_i, cpu_sel_i, cpu_data_i, slv_data_i,
    output cpu_data_o, cpu_stall_o, bus_err_o,
           slv_ce_o, slv_we_o, slv_addr_o, slv_sel_o, slv_data_o
  );

  modport master (
    output cpu_ce_i, cpu_we_i, cpu_addr_i, cpu_sel_i, cpu_data_i, slv_data_i,
    input  cpu_data_o, cpu_stall_o, bus_err_o,
           slv_ce_o, slv_we_o, slv_addr_o, slv_sel_o, slv_data_o
  );

endinterface

// File: rtl/sopc_addr_decode.sv
// Region-select field to slave index plus mapped flag; shared with a future instruction-side bus.
module sopc_addr_decode
  import sopc_data_bus_pkg::*;
#(
  parameter  int unsigned NUM_SLV = 4,
  parameter  int unsigned SEL_HI  = 31,
  parameter  int unsigned SEL_LO  = 28,
  localparam int unsigned FieldW  = SEL_HI - SEL_LO + 1,
  localparam int unsigned IdxW    = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
  input  logic [FieldW-1:0] field_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              mapped_o
);

  assign mapped_o = 32'(field_i) < NUM_SLV;
  assign idx_o    = IdxW'(field_i);

endmodule

// File: rtl/sopc_data_bus.sv
// Data-side interconnect: decodes the CPU address, holds the CPU for per-slave wait states, flags unmapped accesses.
module sopc_data_bus
  import sopc_data_bus_pkg::*;
#(
  parameter int unsigned NUM_SLV  = 4,
  parameter int unsigned SEL_HI   = 31,
  parameter int unsigned SEL_LO   = 28,
  parameter logic [63:0] WAIT_VEC = 64'h5020
) (
  input logic            clk,
  input logic            rst,
  sopc_data_bus_if.slave bus
);

  localparam int unsigned IdxW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  bus_state_e      state_q, state_d;
  bus_req_t        req_q, req_d;
  logic [IdxW-1:0] idx_q, idx_d;
  wait_cnt_t       wcnt_q, wcnt_d;
  reg_bus_t        rdata_q, rdata_d;

  logic [IdxW-1:0] dec_idx;
  logic            dec_mapped;
  wait_cnt_t       wait_sel;
  reg_bus_t        slv_rdata;

  sopc_addr_decode #(
    .NUM_SLV (NUM_SLV),
    .SEL_HI  (SEL_HI),
    .SEL_LO  (SEL_LO)
  ) u_decode (
    .field_i  (bus.cpu_addr_i[SEL_HI:SEL_LO]),
    .idx_o    (dec_idx),
    .mapped_o (dec_mapped)
  );

  // Wait-count lookup for the incoming request and read-data mux for the latched slave.
  always_comb begin
    wait_sel  = '0;
    slv_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (dec_idx == IdxW'(i)) wait_sel = wait_of(WAIT_VEC, i);
      if (idx_q == IdxW'(i))   slv_rdata = bus.slv_data_i[RegBusW*i +: RegBusW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BusIdle;
      req_q   <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    case (state_q)
      BusIdle: begin
        if (bus.cpu_ce_i) begin
          req_d = '{we:    bus.cpu_we_i,
                    addr:  bus.cpu_addr_i,
                    sel:   bus.cpu_sel_i,
                    wdata: bus.cpu_data_i};
          idx_d = dec_idx;
          if (dec_mapped) begin
            wcnt_d  = wait_sel;
            state_d = BusAccess;
          end else begin
            state_d = BusErr;
          end
        end
      end
      BusAccess: begin
        // The slave is sampled in the last ACCESS cycle; writes return zero.
        if (wcnt_q == '0) begin
          rdata_d = req_q.we ? '0 : slv_rdata;
          state_d = BusDone;
        end else begin
          wcnt_d = wcnt_q - wait_cnt_t'(1);
        end
      end
      BusDone: state_d = BusIdle;
      BusErr:  state_d = BusIdle;
      default: state_d = BusIdle;
    endcase
  end

  // Outputs are decoded from registered state only, except the IDLE stall which follows the request.
  always_comb begin
    bus.cpu_stall_o = 1'b0;
    bus.cpu_data_o  = '0;
    bus.bus_err_o   = 1'b0;
    bus.slv_ce_o    = '0;
    bus.slv_we_o    = 1'b0;
    case (state_q)
      BusIdle: bus.cpu_stall_o = bus.cpu_ce_i;
      BusAccess: begin
        bus.cpu_stall_o = 1'b1;
        bus.slv_we_o    = req_q.we;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
          bus.slv_ce_o[i] = (idx_q == IdxW'(i));
        end
      end
      BusDone: bus.cpu_data_o = rdata_q;
      BusErr:  bus.bus_err_o  = 1'b1;
      default: ;
    endcase
    if (rst) bus.cpu_stall_o = 1'b0;
  end

  assign bus.slv_addr_o = req_q.addr;
  assign bus.slv_sel_o  = req_q.sel;
  assign bus.slv_data_o = req_q.wdata;

endmodule

// File: tb/tb_sopc_data_bus.sv
// Randomized and directed bench for sopc_data_bus against a transaction-level latency/data model.
module tb_sopc_data_bus;
  import sopc_data_bus_pkg::*;

  localparam int unsigned NUM_SLV  = 5;
  localparam logic [63:0] WAIT_VEC = 64'hF5020;

  // Wait states per slave as intended by WAIT_VEC: slave4 exercises the 15-wait maximum.
  int unsigned wait_tbl [NUM_SLV] = '{0, 2, 0, 5, 15};

  logic clk;
  logic rst;
  int unsigned n_vec;
  int unsigned n_err;
  logic [31:0] slv_mem [NUM_SLV];
  bit fix_slv;

  sopc_data_bus_if #(.NUM_SLV(NUM_SLV)) bus_if ();

  sopc_data_bus #(
    .NUM_SLV  (NUM_SLV),
    .SEL_HI   (31),
    .SEL_LO   (28),
    .WAIT_VEC (WAIT_VEC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_slv();
    for (int i = 0; i < NUM_SLV; i++) begin
      if (!fix_slv) slv_mem[i] = $urandom;
      bus_if.slv_data_i[32*i +: 32] = slv_mem[i];
    end
  endtask

  // Request inputs outside IDLE must be ignored, so they are scrambled there.
  task automatic scramble_req();
    bus_if.cpu_we_i   = 1'($urandom);
    bus_if.cpu_addr_i = $urandom;
    bus_if.cpu_sel_i  = 4'($urandom);
    bus_if.cpu_data_i = $urandom;
  endtask

  task automatic check_quiet(input string ph);
    chk({ph, "_stall"}, 64'(bus_if.cpu_stall_o), 64'd0);
    chk({ph, "_ce"},    64'(bus_if.slv_ce_o),    64'd0);
    chk({ph, "_we"},    64'(bus_if.slv_we_o),    64'd0);
    chk({ph, "_err"},   64'(bus_if.bus_err_o),   64'd0);
    chk({ph, "_data"},  64'(bus_if.cpu_data_o),  64'd0);
  endtask

  task automatic idle_gap(input int n);
    for (int c = 0; c < n; c++) begin
      bus_if.cpu_ce_i = 1'b0;
      scramble_req();
      drive_slv();
      #1;
      check_quiet("gap");
      next_cycle();
    end
  endtask

  // One CPU access starting in an IDLE cycle; drop_at>0 lowers ce from that ACCESS cycle on,
  // rst_at>0 asserts reset during that ACCESS cycle.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wdata, input int drop_at, input int rst_at);
    int unsigned idx;
    int unsigned w;
    logic [31:0] exp_rd;
    logic [NUM_SLV-1:0] oh;
    idx    = int'(addr[31:28]);
    exp_rd = '0;
    oh     = '0;
    bus_if.cpu_ce_i   = 1'b1;
    bus_if.cpu_we_i   = we;
    bus_if.cpu_addr_i = addr;
    bus_if.cpu_sel_i  = sel;
    bus_if.cpu_data_i = wdata;
    drive_slv();
    #1;
    chk("idle_stall", 64'(bus_if.cpu_stall_o), 64'd1);
    chk("idle_ce",    64'(bus_if.slv_ce_o),    64'd0);
    chk("idle_data",  64'(bus_if.cpu_data_o),  64'd0);
    next_cycle();
    if (idx >= NUM_SLV) begin
      bus_if.cpu_ce_i = 1'($urandom);
      scramble_req();
      #1;
      chk("err_flag",  64'(bus_if.bus_err_o),   64'd1);
      chk("err_stall", 64'(bus_if.cpu_stall_o), 64'd0);
      chk("err_ce",    64'(bus_if.slv_ce_o),    64'd0);
      chk("err_data",  64'(bus_if.cpu_data_o),  64'd0);
      next_cycle();
      return;
    end
    w = wait_tbl[idx];
    oh[idx] = 1'b1;
    for (int k = 1; k <= int'(w) + 1; k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        bus_if.cpu_ce_i = 1'b0;
        #1;
        chk("rst_stall_comb", 64'(bus_if.cpu_stall_o), 64'd0);
        next_cycle();
        rst = 1'b0;
        #1;
        check_quiet("rst");
        chk("rst_addr", 64'(bus_if.slv_addr_o), 64'd0);
        chk("rst_sel",  64'(bus_if.slv_sel_o),  64'd0);
        chk("rst_wdat", 64'(bus_if.slv_data_o), 64'd0);
        next_cycle();
        return;
      end
      bus_if.cpu_ce_i = (drop_at > 0) ? (k < drop_at) : 1'($urandom);
      scramble_req();
      drive_slv();
      #1;
      chk("acc_stall", 64'(bus_if.cpu_stall_o), 64'd1);
      chk("acc_ce",    64'(bus_if.slv_ce_o),    64'(oh));
      chk("acc_we",    64'(bus_if.slv_we_o),    64'(we));
      chk("acc_addr",  64'(bus_if.slv_addr_o),  64'(addr));
      chk("acc_sel",   64'(bus_if.slv_sel_o),   64'(sel));
      chk("acc_wdat",  64'(bus_if.slv_data_o),  64'(wdata));
      chk("acc_data",  64'(bus_if.cpu_data_o),  64'd0);
      if (k == int'(w) + 1) exp_rd = we ? 32'd0 : slv_mem[idx];
      next_cycle();
    end
    bus_if.cpu_ce_i = 1'($urandom);
    scramble_req();
    drive_slv();
    #1;
    chk("done_stall", 64'(bus_if.cpu_stall_o), 64'd0);
    chk("done_ce",    64'(bus_if.slv_ce_o),    64'd0);
    chk("done_we",    64'(bus_if.slv_we_o),    64'd0);
    chk("done_err",   64'(bus_if.bus_err_o),   64'd0);
    chk("done_data",  64'(bus_if.cpu_data_o),  64'(exp_rd));
    next_cycle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    fix_slv = 1'b0;
    rst = 1'b1;
    bus_if.cpu_ce_i   = 1'b0;
    bus_if.cpu_we_i   = 1'b0;
    bus_if.cpu_addr_i = '0;
    bus_if.cpu_sel_i  = '0;
    bus_if.cpu_data_i = '0;
    bus_if.slv_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    chk("reset_addr", 64'(bus_if.slv_addr_o), 64'd0);
    bus_if.cpu_ce_i = 1'b1;
    #1;
    chk("reset_stall_ce", 64'(bus_if.cpu_stall_o), 64'd0);
    next_cycle();
    rst = 1'b0;
    bus_if.cpu_ce_i = 1'b0;
    idle_gap(1);

    fix_slv = 1'b1;
    slv_mem[0] = 32'hDEADBEEF;
    run_txn(32'h0000_0010, 1'b0, 4'hF, 32'h0, 0, -1);
    fix_slv = 1'b0;
    idle_gap(1);
    run_txn(32'h3000_0004, 1'b1, 4'b0011, 32'h1234_5678, 0, -1);
    run_txn(32'h7000_0000, 1'b0, 4'hF, 32'h0, 0, -1);
    run_txn(32'h1000_0020, 1'b0, 4'hF, 32'h0, 0, -1);
    run_txn(32'h2000_0008, 1'b0, 4'hF, 32'h0, 0, -1);
    idle_gap(2);
    run_txn(32'h3000_0100, 1'b0, 4'hF, 32'h0, 2, -1);
    run_txn(32'h3000_0040, 1'b1, 4'hF, 32'hCAFE_F00D, 0, 3);
    run_txn(32'h0000_0044, 1'b0, 4'hF, 32'h0, 0, -1);
    run_txn(32'h4000_0000, 1'b0, 4'hF, 32'h0, 0, -1);
    run_txn(32'hF000_0000, 1'b1, 4'h1, 32'h55AA_55AA, 0, -1);

    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      a = $urandom;
      a[31:28] = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a[31:28] = 4'($urandom_range(8, 15));
      run_txn(a, 1'($urandom), 4'($urandom), $urandom,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, -1);
      idle_gap(int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
